// File: rtl/timer_mmio.sv
// Memory-mapped 32-bit timer: 8-bit prescaler, compare match with optional auto-reload, level IRQ.
// Optional build macro TIMER_MMIO_SNAPSHOT_EN: a read of COUNT byte 0 freezes bytes 1-3 for coherent reads.
module timer_mmio #(
  parameter logic [31:0] BASE_ADDR = 32'h300,
  parameter logic [7:0]  PRESC_RST = 8'h00
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_mmio_addr,
  input  logic [7:0]  i_mmio_data_in,
  output logic [7:0]  o_mmio_data_out,
  input  logic        i_mmio_we,
  input  logic        i_mmio_re,
  output logic        o_irq
);

  localparam logic [3:0] OFF_CTRL   = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h1;
  localparam logic [3:0] OFF_PRESC  = 4'h2;
  localparam logic [3:0] OFF_COUNT0 = 4'h4;
  localparam logic [3:0] OFF_CMP0   = 4'h8;

  logic       hit;
  logic [3:0] off;
  logic       wr;
  logic       rd;

  assign hit = (i_mmio_addr[31:4] == BASE_ADDR[31:4]);
  assign off = i_mmio_addr[3:0];
  assign wr  = i_mmio_we & hit;
  assign rd  = i_mmio_re & hit;

  logic        en_reg, en_next;
  logic        autoreload_reg, autoreload_next;
  logic        irq_en_reg, irq_en_next;
  logic        match_reg, match_next;
  logic [7:0]  presc_reg, presc_next;
  logic [7:0]  pcnt_reg, pcnt_next;
  logic [31:0] count_reg, count_next;
  logic [31:0] cmp_reg, cmp_next;

  logic [3:0]  count_byte_wr;
  logic [3:0]  cmp_byte_wr;
  logic        count_wr;
  logic        ctrl_wr;
  logic        presc_wr;
  logic        match_clr;
  logic        tick;
  logic        count_hit;
  logic        match_evt;
  logic [31:0] count_inc;
  logic [31:0] count_adv;
  logic [31:0] count_base;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte
      localparam logic [3:0] CNT_OFF = OFF_COUNT0 + 4'(gi);
      localparam logic [3:0] CMP_OFF = OFF_CMP0 + 4'(gi);

      assign count_byte_wr[gi] = wr && (off == CNT_OFF);
      assign cmp_byte_wr[gi]   = wr && (off == CMP_OFF);

      // A CPU byte write beats the tick; untouched bytes keep their pre-tick value.
      assign count_next[8*gi +: 8] = count_byte_wr[gi] ? i_mmio_data_in :
                                     count_wr          ? count_reg[8*gi +: 8] :
                                                         count_base[8*gi +: 8];
      assign cmp_next[8*gi +: 8]   = cmp_byte_wr[gi] ? i_mmio_data_in : cmp_reg[8*gi +: 8];
    end
  endgenerate

  assign count_wr   = |count_byte_wr;
  assign ctrl_wr    = wr && (off == OFF_CTRL);
  assign presc_wr   = wr && (off == OFF_PRESC);
  assign match_clr  = wr && (off == OFF_STATUS) && i_mmio_data_in[0];

  assign tick       = en_reg && (pcnt_reg == presc_reg);
  assign count_hit  = (count_reg == cmp_reg);
  assign match_evt  = tick && !count_wr && count_hit;
  assign count_inc  = count_reg + 32'd1;
  assign count_adv  = (count_hit && autoreload_reg) ? 32'd0 : count_inc;
  assign count_base = tick ? count_adv : count_reg;

  always_comb begin
    en_next         = en_reg;
    autoreload_next = autoreload_reg;
    irq_en_next     = irq_en_reg;
    presc_next      = presc_reg;
    pcnt_next       = pcnt_reg + 8'd1;
    if (ctrl_wr) begin
      en_next         = i_mmio_data_in[0];
      autoreload_next = i_mmio_data_in[1];
      irq_en_next     = i_mmio_data_in[2];
    end
    if (presc_wr) begin
      presc_next = i_mmio_data_in;
    end
    if (presc_wr || !en_reg || tick) begin
      pcnt_next = 8'd0;
    end
    // Set wins over a simultaneous write-1-to-clear.
    match_next = match_evt | (match_reg & ~match_clr);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      en_reg         <= 1'b0;
      autoreload_reg <= 1'b0;
      irq_en_reg     <= 1'b0;
      match_reg      <= 1'b0;
      presc_reg      <= PRESC_RST;
      pcnt_reg       <= 8'd0;
      count_reg      <= 32'd0;
      cmp_reg        <= 32'd0;
    end else begin
      en_reg         <= en_next;
      autoreload_reg <= autoreload_next;
      irq_en_reg     <= irq_en_next;
      match_reg      <= match_next;
      presc_reg      <= presc_next;
      pcnt_reg       <= pcnt_next;
      count_reg      <= count_next;
      cmp_reg        <= cmp_next;
    end
  end

`ifdef TIMER_MMIO_SNAPSHOT_EN
  logic [23:0] snap_reg, snap_next;

  assign snap_next = (rd && (off == OFF_COUNT0)) ? count_reg[31:8] : snap_reg;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      snap_reg <= 24'd0;
    end else begin
      snap_reg <= snap_next;
    end
  end
`endif

  logic [7:0] rdata;

  always_comb begin
    rdata = 8'h00;
    if (rd) begin
      case (off)
        4'h0: rdata = {5'd0, irq_en_reg, autoreload_reg, en_reg};
        4'h1: rdata = {7'd0, match_reg};
        4'h2: rdata = presc_reg;
        4'h4: rdata = count_reg[7:0];
`ifdef TIMER_MMIO_SNAPSHOT_EN
        4'h5: rdata = snap_reg[7:0];
        4'h6: rdata = snap_reg[15:8];
        4'h7: rdata = snap_reg[23:16];
`else
        4'h5: rdata = count_reg[15:8];
        4'h6: rdata = count_reg[23:16];
        4'h7: rdata = count_reg[31:24];
`endif
        4'h8: rdata = cmp_reg[7:0];
        4'h9: rdata = cmp_reg[15:8];
        4'hA: rdata = cmp_reg[23:16];
        4'hB: rdata = cmp_reg[31:24];
        default: rdata = 8'h00;
      endcase
    end
  end

  assign o_mmio_data_out = rdata;
  assign o_irq           = match_reg & irq_en_reg;

endmodule

// File: tb/tb_timer_mmio.sv
// Bench for timer_mmio: directed scenarios plus random bus traffic against a behavioural model.
// Honours TIMER_MMIO_SNAPSHOT_EN the same way the design does.
module tb_timer_mmio;

  localparam logic [31:0] BASE       = 32'h300;
  localparam logic [7:0]  PRESC_INIT = 8'h5A;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] mmio_addr = '0;
  logic [7:0]  mmio_data_in = '0;
  logic [7:0]  mmio_data_out;
  logic        mmio_we = 1'b0;
  logic        mmio_re = 1'b0;
  logic        irq;

  int checks = 0;
  int failures = 0;
  bit chk_on = 1'b0;

  timer_mmio #(.BASE_ADDR(BASE), .PRESC_RST(PRESC_INIT)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_mmio_addr(mmio_addr),
    .i_mmio_data_in(mmio_data_in),
    .o_mmio_data_out(mmio_data_out),
    .i_mmio_we(mmio_we),
    .i_mmio_re(mmio_re),
    .o_irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Behavioural model of the register file and timer.
  bit          m_en, m_auto, m_irqen, m_match;
  logic [7:0]  m_presc = PRESC_INIT;
  logic [7:0]  m_pcnt = '0;
  logic [31:0] m_count = '0;
  logic [31:0] m_cmp = '0;
  logic [23:0] m_snap = '0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model_read(input logic re, input logic [31:0] addr);
    logic [7:0] r;
    int k;
    r = 8'h00;
    k = int'(addr[3:0]);
    if (re && addr[31:4] == BASE[31:4]) begin
      if (k == 0) r = {5'd0, m_irqen, m_auto, m_en};
      else if (k == 1) r = {7'd0, m_match};
      else if (k == 2) r = m_presc;
      else if (k >= 4 && k <= 7) begin
        r = m_count[8*(k-4) +: 8];
`ifdef TIMER_MMIO_SNAPSHOT_EN
        if (k != 4) r = m_snap[8*(k-5) +: 8];
`endif
      end else if (k >= 8 && k <= 11) r = m_cmp[8*(k-8) +: 8];
    end
    return r;
  endfunction

  task automatic model_step(input logic rs, input logic we, input logic re,
                            input logic [31:0] addr, input logic [7:0] din);
    bit hit, wr, tick, cwr, evt;
    int k;
    logic [31:0] n_count;
    if (!rs) begin
      m_en = 0; m_auto = 0; m_irqen = 0; m_match = 0;
      m_presc = PRESC_INIT; m_pcnt = 0; m_count = 0; m_cmp = 0; m_snap = 0;
      return;
    end
    hit  = (addr[31:4] == BASE[31:4]);
    wr   = we && hit;
    k    = int'(addr[3:0]);
    tick = m_en && (m_pcnt == m_presc);
    cwr  = wr && k >= 4 && k <= 7;
    evt  = tick && !cwr && (m_count == m_cmp);
    if (re && hit && k == 4) m_snap = m_count[31:8];
    n_count = m_count;
    if (cwr) n_count[8*(k-4) +: 8] = din;
    else if (tick) n_count = (evt && m_auto) ? 32'd0 : m_count + 32'd1;
    if (wr && k == 1 && din[0]) m_match = 0;
    if (evt) m_match = 1;
    if ((wr && k == 2) || !m_en || tick) m_pcnt = 0;
    else m_pcnt = m_pcnt + 8'd1;
    if (wr && k == 0) begin m_en = din[0]; m_auto = din[1]; m_irqen = din[2]; end
    if (wr && k == 2) m_presc = din;
    if (wr && k >= 8 && k <= 11) m_cmp[8*(k-8) +: 8] = din;
    m_count = n_count;
  endtask

  // One bus cycle: drive at negedge, compare combinational outputs, then advance the model at the edge.
  task automatic bus_cycle(input logic rs, input logic we, input logic re,
                           input logic [31:0] addr, input logic [7:0] din, output logic [7:0] rdata);
    @(negedge clk);
    rst = rs; mmio_we = we; mmio_re = re; mmio_addr = addr; mmio_data_in = din;
    #1;
    rdata = mmio_data_out;
    if (chk_on) begin
      check_value("rdata", {24'd0, rdata}, {24'd0, model_read(re, addr)});
      check_value("irq", {31'd0, irq}, {31'd0, m_match & m_irqen});
    end
    if (we || re)
      $display("TX t=%0t rst=%0d we=%0d re=%0d addr=%h wdata=%h rdata=%h",
               $time, rs, we, re, addr, din, rdata);
    @(posedge clk);
    model_step(rs, we, re, addr, din);
  endtask

  task automatic wr(input logic [3:0] o, input logic [7:0] d);
    logic [7:0] v;
    bus_cycle(1'b1, 1'b1, 1'b0, BASE | 32'(o), d, v);
  endtask

  task automatic wr32(input logic [3:0] o, input logic [31:0] d);
    for (int b = 0; b < 4; b++) wr(o + 4'(b), d[8*b +: 8]);
  endtask

  task automatic rd(input logic [3:0] o, output logic [7:0] v);
    bus_cycle(1'b1, 1'b0, 1'b1, BASE | 32'(o), 8'h00, v);
  endtask

  task automatic idle(input int n);
    logic [7:0] v;
    repeat (n) bus_cycle(1'b1, 1'b0, 1'b0, BASE, 8'h00, v);
  endtask

  // Runs idle cycles until irq rises; returns the number of edges taken (limit on timeout).
  task automatic wait_irq(input int limit, output int n);
    n = 0;
    while (n < limit) begin
      idle(1);
      n++;
      #1;
      if (irq) break;
    end
  endtask

  initial begin
    logic [7:0] v;
    int n;

    // Reset with bus activity that must be ignored.
    bus_cycle(1'b0, 1'b1, 1'b1, BASE, 8'hFF, v);
    chk_on = 1'b1;
    for (int c = 0; c < 3; c++)
      bus_cycle(1'b0, 1'(c % 2), 1'(~c % 2), BASE | 32'(c), 8'hFF, v);
    rd(4'h0, v); check_value("rst_ctrl", {24'd0, v}, 32'h00);
    rd(4'h1, v); check_value("rst_status", {24'd0, v}, 32'h00);
    rd(4'h2, v); check_value("rst_presc", {24'd0, v}, {24'd0, PRESC_INIT});
    rd(4'h4, v); check_value("rst_count0", {24'd0, v}, 32'h00);
    rd(4'h7, v); check_value("rst_count3", {24'd0, v}, 32'h00);
    rd(4'h8, v); check_value("rst_cmp0", {24'd0, v}, 32'h00);
    check_value("rst_irq", {31'd0, irq}, 32'd0);

    // Periodic auto-reload match with interrupt.
    wr(4'h2, 8'd3);
    wr32(4'h8, 32'd5);
    wr(4'h0, 8'h07);
    wait_irq(100, n);
    check_value("period_first", n, 24);
    rd(4'h4, v); check_value("period_count0", {24'd0, v}, 32'h00);
    wr(4'h1, 8'h01);
    wait_irq(100, n);
    check_value("period_repeat", n, 22);
    wr(4'h0, 8'h00);
    wr(4'h1, 8'h01);

    // Wrap from all-ones without a match, then match at CMP.
    wr32(4'h4, 32'hFFFF_FFFF);
    wr32(4'h8, 32'd10);
    wr(4'h2, 8'd0);
    wr(4'h0, 8'h01);
    idle(1);
    rd(4'h4, v); check_value("wrap_count0", {24'd0, v}, 32'h00);
    rd(4'h1, v); check_value("wrap_nomatch", {24'd0, v}, 32'h00);
    idle(8);
    rd(4'h1, v); check_value("wrap_premat", {24'd0, v}, 32'h00);
    rd(4'h1, v); check_value("wrap_match", {24'd0, v}, 32'h01);

    // W1C in the same cycle as a match event: set wins.
    wr(4'h0, 8'h00);
    wr(4'h1, 8'h01);
    wr32(4'h4, 32'd3);
    wr32(4'h8, 32'd5);
    wr(4'h0, 8'h01);
    idle(2);
    wr(4'h1, 8'h01);
    rd(4'h1, v); check_value("w1c_collide", {24'd0, v}, 32'h01);
    wr(4'h1, 8'h01);
    rd(4'h1, v); check_value("w1c_clear", {24'd0, v}, 32'h00);

    // COUNT byte write on a tick cycle.
    wr(4'h0, 8'h00);
    wr32(4'h4, 32'h1234_5678);
    wr32(4'h8, 32'hFFFF_FFFF);
    wr(4'h0, 8'h01);
    idle(1);
    wr(4'h4, 8'hAA);
    rd(4'h4, v); check_value("coll_byte0", {24'd0, v}, 32'hAA);
    rd(4'h5, v); check_value("coll_byte1", {24'd0, v}, 32'h56);
    rd(4'h6, v); check_value("coll_byte2", {24'd0, v}, 32'h34);
    rd(4'h7, v); check_value("coll_byte3", {24'd0, v}, 32'h12);

    // Snapshot coherence across the 0xFF -> 0x100 carry.
    wr(4'h0, 8'h00);
    wr32(4'h4, 32'h0000_00FF);
    wr(4'h0, 8'h01);
    rd(4'h4, v); check_value("snap_byte0", {24'd0, v}, 32'hFF);
    rd(4'h5, v);
`ifdef TIMER_MMIO_SNAPSHOT_EN
    check_value("snap_byte1", {24'd0, v}, 32'h00);
`else
    check_value("snap_byte1", {24'd0, v}, 32'h01);
`endif

    // Address decode: outside the block and unmapped offsets.
    wr(4'h0, 8'h00);
    bus_cycle(1'b1, 1'b1, 1'b0, BASE + 32'h10, 8'h07, v);
    wr(4'h3, 8'h07);
    bus_cycle(1'b1, 1'b0, 1'b1, BASE + 32'h10, 8'h00, v);
    check_value("dec_outside", {24'd0, v}, 32'h00);
    rd(4'h3, v); check_value("dec_unmapped", {24'd0, v}, 32'h00);
    rd(4'h0, v); check_value("dec_ctrl", {24'd0, v}, 32'h00);

    // Random traffic, including occasional mid-count resets.
    for (int i = 0; i < 1500; i++) begin
      logic rs, we, re;
      logic [3:0] o;
      logic [31:0] a;
      logic [7:0] d;
      rs = ($urandom_range(0, 299) != 0);
      we = ($urandom_range(0, 2) == 0);
      re = 1'($urandom_range(0, 1));
      o  = 4'($urandom_range(0, 15));
      a  = ($urandom_range(0, 15) == 0) ? (($urandom() & 32'hFFFF_FFF0) | 32'(o)) : (BASE | 32'(o));
      d  = 8'($urandom_range(0, 255));
      case (o)
        4'h2: d = 8'($urandom_range(0, 3));
        4'h8: d = 8'($urandom_range(0, 20));
        4'h5, 4'h6, 4'h7, 4'h9, 4'hA, 4'hB: if ($urandom_range(0, 7) != 0) d = 8'h00;
        default: ;
      endcase
      bus_cycle(rs, we, re, a, d, v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/timer_mmio.md
TIMER_MMIO -- requirements
Module: timer_mmio

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h300, giving the byte address of register offset 0.
REQ-002 SHALL have parameter PRESC_RST, default 8'h00, giving the reset value of the PRESC register.
REQ-003 SHALL have port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_rst, input, 1 bit: reset, synchronous, active-low (asserted when 0).
REQ-005 SHALL have port i_mmio_addr, input, 32 bits: byte address of the access.
REQ-006 SHALL have port i_mmio_data_in, input, 8 bits: write data.
REQ-007 SHALL have port o_mmio_data_out, output, 8 bits: read data.
REQ-008 SHALL have port i_mmio_we, input, 1 bit: write strobe, one access per cycle.
REQ-009 SHALL have port i_mmio_re, input, 1 bit: read strobe, one access per cycle.
REQ-010 SHALL have port o_irq, output, 1 bit: level interrupt request.

Function
REQ-011 SHALL respond only when i_mmio_addr[31:4] == BASE_ADDR[31:4]; offset = i_mmio_addr[3:0]; all other addresses are ignored.
REQ-012 Register map SHALL be: 0x0 CTRL (bit0 EN, bit1 AUTORELOAD, bit2 IRQ_EN, bits 7:3 read 0); 0x1 STATUS (bit0 MATCH); 0x2 PRESC; 0x4-0x7 COUNT bytes 0-3 (0x4 = LSB); 0x8-0xB CMP bytes 0-3; all other offsets read 0, writes ignored.
REQ-013 Reads SHALL be combinational: o_mmio_data_out is valid in the same cycle as i_mmio_re and addr; it is 8'h00 when i_mmio_re=0 or the address misses.
REQ-014 Writes SHALL take effect at the rising edge at which i_mmio_we=1 and SHALL be visible to a read in the next cycle.
REQ-015 STATUS.MATCH SHALL be write-1-to-clear; writing 0 SHALL leave it unchanged.
REQ-016 Prescaler: an 8-bit counter; while EN=1 it increments each cycle; when it equals PRESC it produces a one-cycle tick and returns to 0; PRESC=0 SHALL produce a tick every cycle.
REQ-017 While EN=0 the prescaler SHALL be held at 0, no ticks occur, and COUNT holds its value.
REQ-018 On a tick: if COUNT == CMP, MATCH SHALL be set, and COUNT SHALL become 0 if AUTORELOAD=1, else COUNT+1; otherwise COUNT SHALL become COUNT+1, wrapping 32'hFFFFFFFF -> 0 without setting MATCH.
REQ-019 A CPU write to any COUNT byte in the same cycle as a tick SHALL win: the written byte takes the new value, the other bytes keep their pre-tick value, and no match is evaluated that cycle.
REQ-020 A write of 1 to MATCH in the same cycle as a match event SHALL leave MATCH=1 (set wins).
REQ-021 A write to PRESC SHALL clear the prescaler counter to 0 in the same edge.
REQ-022 o_irq SHALL be registered-state combinational: o_irq = MATCH & IRQ_EN; no extra latency beyond MATCH.
REQ-023 Simultaneous i_mmio_we and i_mmio_re SHALL perform both: the read returns the pre-write value.

Reset
REQ-024 While i_rst=0 at a rising edge, CTRL, STATUS, COUNT, CMP, the prescaler counter and the snapshot register SHALL be cleared to 0, PRESC set to PRESC_RST, and writes ignored.
REQ-025 During and after reset, o_irq SHALL be 0 and o_mmio_data_out SHALL be 0 unless a read is presented; reset asserted mid-count SHALL abandon the count with no tick.

Configuration
REQ-026 Macro TIMER_MMIO_SNAPSHOT_EN defined: a read of offset 0x4 returns the live COUNT[7:0] and, at that edge, latches COUNT[31:8] into a 24-bit snapshot; reads of 0x5-0x7 return snapshot bytes.
REQ-027 Macro TIMER_MMIO_SNAPSHOT_EN undefined: reads of 0x4-0x7 return live COUNT bytes and no snapshot register exists.

Verification
REQ-028 Reset: hold i_rst=0 for 3 cycles with we/re toggling -> all reads 0 after release, PRESC reads PRESC_RST, o_irq=0.
REQ-029 Period: PRESC=3, CMP=5, CTRL=3'b111 -> MATCH set and o_irq=1 on the 24th tick-eligible cycle after EN, COUNT reads 0, repeating every 24 cycles.
REQ-030 Wrap: COUNT=32'hFFFFFFFF, CMP=10, PRESC=0, EN=1, AUTORELOAD=0 -> COUNT=0 after 1 cycle, MATCH=0; MATCH=1 after 11 more cycles.
REQ-031 Collision: W1C MATCH in the cycle a match occurs -> MATCH stays 1; write COUNT byte0=8'hAA on a tick cycle -> byte0 reads 8'hAA, upper bytes unchanged.
REQ-032 Snapshot (macro on): COUNT=32'h000000FF, PRESC=0, EN=1; read 0x4 then 0x5 on the next cycle -> byte0 8'hFF, byte1 8'h00 although live COUNT is 32'h00000100; macro off -> byte1 8'h01.
REQ-033 Decode: write 8'h07 to BASE_ADDR+0x10 and BASE_ADDR+0x3 -> no register changes, reads return 8'h00.
